controle_param: RTL and testbench
=================================

# controle_param

Parametrised multi-cycle control unit for the simple processor datapath: decodes a 4-bit opcode plus two register fields and sequences one-hot register, ALU, memory and stack-pointer strobes through states T0..T3. It generalises the register count and data width, implements PUSH/POP, supports stalling on `run`, and flags illegal opcodes. It sits between the instruction register and the datapath (register file, ALU/G, address/dout registers, memory).

## Interface
- `NREG`, 8: number of general registers; power of two, ≥4.
- `DATA_W`, 16: datapath width (width of `G`).
- `SP_IDX`, 5: index of the register used as stack pointer; must be < NREG.
- SEL_W = $clog2(NREG) (derived); IR_W = 4 + 2*SEL_W (derived).

- `clock`  in  1  single clock; all state changes on rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `run`  in  1  advance enable; low stalls the sequencer.
- `ir`  in  IR_W  instruction: [IR_W-1:2*SEL_W] opcode, [2*SEL_W-1:SEL_W] X, [SEL_W-1:0] Y.
- `G`  in  DATA_W  ALU result register, used by MVNZ.
- `r_in`  out  NREG  one-hot register write enables.
- `r_out`  out  NREG  one-hot register bus drivers.
- `din_out`, `a_in`, `g_in`, `g_out`, `addr_in`, `dout_in`, `wren`, `mem_rd`, `mem_out`, `sp_inc`, `sp_dec`  out  1 each  datapath strobes.
- `alu_op`  out  3  000 add, 001 sub, 010 slt, 011 cmp-equal; 000 when g_in low.
- `done`  out  1  high during last step of an instruction.
- `busy`  out  1  high in T1..T3.
- `illegal`  out  1  pulse with `done` for unknown opcode.

## Operation
- Opcodes: MV 0, MVI 1, ADD 2, SUB 3, LD 4, ST 5, MVNZ 6, SLT 7, CMP 8, PUSH 9, POP 10; 11–15 illegal.
- State register holds T0..T3 and latched ir_q. T0 decodes live `ir`; ir_q captured on the edge leaving T0. T1..T3 decode ir_q.
- All outputs combinational from (state, ir/ir_q, run, G); every output 0 when run=0.
- Steps (Rx = reg X, Ry = reg Y, Rsp = reg SP_IDX):
  - MV: T0 r_out[Y], r_in[X], done.
  - MVI: T0 din_out, r_in[X], done.
  - MVNZ: T0 r_out[Y], r_in[X] only if G≠0, done regardless.
  - ADD/SUB/SLT/CMP: T0 r_out[X], a_in; T1 r_out[Y], g_in, alu_op; T2 g_out, r_in[X], done.
  - LD: T0 r_out[Y], addr_in; T1 mem_rd; T2 idle; T3 mem_out, r_in[X], done.
  - ST: T0 r_out[Y], addr_in; T1 r_out[X], dout_in; T2 wren, done.
  - PUSH: T0 sp_dec; T1 r_out[SP_IDX], addr_in; T2 r_out[X], dout_in; T3 wren, done.
  - POP: T0 r_out[SP_IDX], addr_in; T1 mem_rd; T2 mem_out, r_in[X], sp_inc, done.
  - Illegal: T0 done, illegal; no other strobe.
- Transitions: any state with done and run=1 -> T0; otherwise Tn -> Tn+1 when run=1; run=0 holds state and ir_q.
- At most one bit of r_in and of r_out high in any cycle.

## Timing
- Reset (async assert, sync-safe deassert): state T0, ir_q 0; all outputs 0 while resetn low.
- Latency (cycles with run=1): MV/MVI/MVNZ/illegal 1; ST/POP/ALU ops 3; LD/PUSH 4.
- Back-to-back: new instruction decoded in the cycle after done; no dead cycle.
- Stall: run low in T1..T3 freezes; outputs resume identically when run returns. run low in T0: no decode, ir not captured.
- `ir` may change freely after leaving T0; only ir_q used.
- Reset mid-instruction abandons it; no partial wren/sp strobes after resetn falls.
- MVNZ samples G in T0 combinationally.

## Test plan
- Reset with run=1, ir=ADD: resetn low -> all outputs 0, busy 0; release -> T0 decode, a_in=1, r_out=8'h01 for X=0.
- MV R3,R6 (ir=0x01E? opcode 0, X=3, Y=6): one cycle r_out=8'h40, r_in=8'h08, done=1; next cycle new decode.
- SUB R1,R2: T0 r_out=0x02,a_in; T1 r_out=0x04,g_in,alu_op=001; T2 g_out,r_in=0x02,done; run dropped in T1 for 2 cycles -> outputs 0, resumes T1.
- MVNZ R4,R5 with G=0 -> done, r_in=0; with G=16'h0001 -> r_in=0x10, r_out=0x20.
- PUSH R2 then POP R7: sp_dec T0; r_out=0x20,addr_in T1; r_out=0x04,dout_in T2; wren,done T3; POP: r_out=0x20 T0, mem_rd T1, mem_out,r_in=0x80,sp_inc,done T2.
- ir opcode 4'hF -> done=illegal=1 in one cycle, no strobes; NREG=16 build: LD R15,R9 -> r_out=16'h0200 T0, r_in=16'h8000 T3.

Source files
------------

// File: rtl/controle_param.sv
// rtl/controle_param.sv - multi-cycle control unit sequencing datapath strobes through T0..T3
// Decodes live ir in T0 and the latched ir_q in T1..T3; every output is gated by run and resetn.
module controle_param #(
  parameter int NREG   = 8,
  parameter int DATA_W = 16,
  parameter int SP_IDX = 5,
  localparam int SEL_W = $clog2(NREG),
  localparam int IR_W  = 4 + 2*SEL_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [IR_W-1:0]   ir,
  input  logic [DATA_W-1:0] G,
  output logic [NREG-1:0]   r_in,
  output logic [NREG-1:0]   r_out,
  output logic              din_out,
  output logic              a_in,
  output logic              g_in,
  output logic              g_out,
  output logic              addr_in,
  output logic              dout_in,
  output logic              wren,
  output logic              mem_rd,
  output logic              mem_out,
  output logic              sp_inc,
  output logic              sp_dec,
  output logic [2:0]        alu_op,
  output logic              done,
  output logic              busy,
  output logic              illegal
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVNZ = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_CMP  = 4'd8;
  localparam logic [3:0] OP_PUSH = 4'd9;
  localparam logic [3:0] OP_POP  = 4'd10;

  localparam logic [SEL_W-1:0] SP_SEL = SEL_W'(SP_IDX);

  state_t            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   instr;
  logic [3:0]        opcode;
  logic [SEL_W-1:0]  rx, ry;
  logic              rin_en, rout_en;
  logic [SEL_W-1:0]  rin_idx, rout_idx;
  logic [2:0]        alu_code;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    din_out  = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    addr_in  = 1'b0;
    dout_in  = 1'b0;
    wren     = 1'b0;
    mem_rd   = 1'b0;
    mem_out  = 1'b0;
    sp_inc   = 1'b0;
    sp_dec   = 1'b0;
    alu_op   = 3'b000;
    done     = 1'b0;
    illegal  = 1'b0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_idx  = '0;
    rout_idx = '0;
    state_d  = state_q;
    ir_d     = ir_q;

    instr  = (state_q == T0) ? ir : ir_q;
    opcode = instr[IR_W-1:2*SEL_W];
    rx     = instr[2*SEL_W-1:SEL_W];
    ry     = instr[SEL_W-1:0];

    case (opcode)
      OP_SUB:  alu_code = 3'b001;
      OP_SLT:  alu_code = 3'b010;
      OP_CMP:  alu_code = 3'b011;
      default: alu_code = 3'b000;
    endcase

    // Gating on resetn keeps every strobe quiet while reset is asserted.
    if (resetn && run) begin
      case (opcode)
        OP_MV:   begin rout_en = 1'b1; rout_idx = ry; rin_en = 1'b1; rin_idx = rx; done = 1'b1; end
        OP_MVI:  begin din_out = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1; end
        OP_MVNZ: begin rout_en = 1'b1; rout_idx = ry; rin_en = (G != '0); rin_idx = rx; done = 1'b1; end
        OP_ADD, OP_SUB, OP_SLT, OP_CMP: begin
          case (state_q)
            T0:      begin rout_en = 1'b1; rout_idx = rx; a_in = 1'b1; end
            T1:      begin rout_en = 1'b1; rout_idx = ry; g_in = 1'b1; alu_op = alu_code; end
            T2:      begin g_out = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1; end
            default: ;
          endcase
        end
        OP_LD: begin
          case (state_q)
            T0:      begin rout_en = 1'b1; rout_idx = ry; addr_in = 1'b1; end
            T1:      mem_rd = 1'b1;
            T3:      begin mem_out = 1'b1; rin_en = 1'b1; rin_idx = rx; done = 1'b1; end
            default: ;
          endcase
        end
        OP_ST: begin
          case (state_q)
            T0:      begin rout_en = 1'b1; rout_idx = ry; addr_in = 1'b1; end
            T1:      begin rout_en = 1'b1; rout_idx = rx; dout_in = 1'b1; end
            T2:      begin wren = 1'b1; done = 1'b1; end
            default: ;
          endcase
        end
        OP_PUSH: begin
          case (state_q)
            T0:      sp_dec = 1'b1;
            T1:      begin rout_en = 1'b1; rout_idx = SP_SEL; addr_in = 1'b1; end
            T2:      begin rout_en = 1'b1; rout_idx = rx; dout_in = 1'b1; end
            T3:      begin wren = 1'b1; done = 1'b1; end
            default: ;
          endcase
        end
        OP_POP: begin
          case (state_q)
            T0:      begin rout_en = 1'b1; rout_idx = SP_SEL; addr_in = 1'b1; end
            T1:      mem_rd = 1'b1;
            T2:      begin mem_out = 1'b1; rin_en = 1'b1; rin_idx = rx; sp_inc = 1'b1; done = 1'b1; end
            default: ;
          endcase
        end
        default: begin
          if (state_q == T0) begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        end
      endcase

      if (state_q == T0) ir_d = ir;
      state_d = done ? T0 : state_t'(state_q + 2'd1);
    end

    r_in  = rin_en  ? (NREG'(1) << rin_idx)  : '0;
    r_out = rout_en ? (NREG'(1) << rout_idx) : '0;
    busy  = resetn && run && (state_q != T0);
  end

endmodule

// File: tb/tb_controle_param.sv
// tb/tb_controle_param.sv - directed self-checking bench for controle_param
// Two instances: the default NREG=8 build and an NREG=16 build for wide register fields.
module tb_controle_param;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [9:0]  ir = '0;
  logic [11:0] ir16 = '0;
  logic [15:0] G = '0;

  logic [7:0]  r_in, r_out;
  logic        din_out, a_in, g_in, g_out, addr_in, dout_in, wren, mem_rd, mem_out;
  logic        sp_inc, sp_dec, done, busy, illegal;
  logic [2:0]  alu_op;

  logic [15:0] w_r_in, w_r_out;
  logic        w_din_out, w_a_in, w_g_in, w_g_out, w_addr_in, w_dout_in, w_wren, w_mem_rd, w_mem_out;
  logic        w_sp_inc, w_sp_dec, w_done, w_busy, w_illegal;
  logic [2:0]  w_alu_op;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  controle_param #(.NREG(8), .DATA_W(16), .SP_IDX(5)) dut (
    .clock(clock), .resetn(resetn), .run(run), .ir(ir), .G(G),
    .r_in(r_in), .r_out(r_out), .din_out(din_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
    .addr_in(addr_in), .dout_in(dout_in), .wren(wren), .mem_rd(mem_rd), .mem_out(mem_out),
    .sp_inc(sp_inc), .sp_dec(sp_dec), .alu_op(alu_op), .done(done), .busy(busy), .illegal(illegal)
  );

  controle_param #(.NREG(16), .DATA_W(16), .SP_IDX(5)) dut16 (
    .clock(clock), .resetn(resetn), .run(run), .ir(ir16), .G(G),
    .r_in(w_r_in), .r_out(w_r_out), .din_out(w_din_out), .a_in(w_a_in), .g_in(w_g_in), .g_out(w_g_out),
    .addr_in(w_addr_in), .dout_in(w_dout_in), .wren(w_wren), .mem_rd(w_mem_rd), .mem_out(w_mem_out),
    .sp_inc(w_sp_inc), .sp_dec(w_sp_dec), .alu_op(w_alu_op), .done(w_done), .busy(w_busy), .illegal(w_illegal)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [9:0] mk(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    return {op, x, y};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Packs the 1-bit strobes so a whole step is one comparison.
  function automatic logic [15:0] strobes();
    return {din_out, a_in, g_in, g_out, addr_in, dout_in, wren, mem_rd,
            mem_out, sp_inc, sp_dec, done, busy, illegal, 2'b00};
  endfunction

  localparam logic [15:0] S_DIN = 16'h8000, S_AIN = 16'h4000, S_GIN = 16'h2000, S_GOUT = 16'h1000;
  localparam logic [15:0] S_ADDR = 16'h0800, S_DOUT = 16'h0400, S_WREN = 16'h0200, S_MRD = 16'h0100;
  localparam logic [15:0] S_MOUT = 16'h0080, S_SPI = 16'h0040, S_SPD = 16'h0020, S_DONE = 16'h0010;
  localparam logic [15:0] S_BUSY = 16'h0008, S_ILL = 16'h0004;

  task automatic step_chk(input string tag, input logic [7:0] e_rout, input logic [7:0] e_rin,
                          input logic [2:0] e_alu, input logic [15:0] e_str);
    expect_eq({tag, ".r_out"}, r_out, e_rout);
    expect_eq({tag, ".r_in"}, r_in, e_rin);
    expect_eq({tag, ".alu_op"}, alu_op, e_alu);
    expect_eq({tag, ".strobes"}, strobes(), e_str);
  endtask

  initial begin
    // Reset with run=1 and ADD R0,R1 presented
    run = 1'b1;
    ir = mk(4'd2, 3'd0, 3'd1);
    ir16 = '0;
    #1;
    step_chk("reset", 8'h00, 8'h00, 3'b000, 16'h0000);
    tick();
    step_chk("reset_held", 8'h00, 8'h00, 3'b000, 16'h0000);
    resetn = 1'b1;
    #1;
    step_chk("add.t0", 8'h01, 8'h00, 3'b000, S_AIN);
    tick();
    step_chk("add.t1", 8'h02, 8'h00, 3'b000, S_GIN | S_BUSY);
    tick();
    step_chk("add.t2", 8'h00, 8'h01, 3'b000, S_GOUT | S_DONE | S_BUSY);
    tick();

    // MV R3,R6 followed immediately by MVI R2
    ir = mk(4'd0, 3'd3, 3'd6);
    #1;
    step_chk("mv", 8'h40, 8'h08, 3'b000, S_DONE);
    tick();
    ir = mk(4'd1, 3'd2, 3'd0);
    #1;
    step_chk("mvi", 8'h00, 8'h04, 3'b000, S_DIN | S_DONE);
    tick();

    // SUB R1,R2 with a 2-cycle stall in T1 and ir scrambled after T0
    ir = mk(4'd3, 3'd1, 3'd2);
    #1;
    step_chk("sub.t0", 8'h02, 8'h00, 3'b000, S_AIN);
    tick();
    ir = 10'h3FF;
    #1;
    step_chk("sub.t1", 8'h04, 8'h00, 3'b001, S_GIN | S_BUSY);
    run = 1'b0;
    #1;
    step_chk("sub.stall0", 8'h00, 8'h00, 3'b000, 16'h0000);
    tick();
    step_chk("sub.stall1", 8'h00, 8'h00, 3'b000, 16'h0000);
    tick();
    run = 1'b1;
    #1;
    step_chk("sub.t1_resume", 8'h04, 8'h00, 3'b001, S_GIN | S_BUSY);
    tick();
    step_chk("sub.t2", 8'h00, 8'h02, 3'b000, S_GOUT | S_DONE | S_BUSY);
    tick();

    // MVNZ R4,R5 with G zero and nonzero
    ir = mk(4'd6, 3'd4, 3'd5);
    G = 16'h0000;
    #1;
    step_chk("mvnz.g0", 8'h20, 8'h00, 3'b000, S_DONE);
    G = 16'h0001;
    #1;
    step_chk("mvnz.g1", 8'h20, 8'h10, 3'b000, S_DONE);
    tick();
    G = 16'h0000;

    // PUSH R2 then POP R7 (SP is R5)
    ir = mk(4'd9, 3'd2, 3'd0);
    #1;
    step_chk("push.t0", 8'h00, 8'h00, 3'b000, S_SPD);
    tick();
    step_chk("push.t1", 8'h20, 8'h00, 3'b000, S_ADDR | S_BUSY);
    tick();
    step_chk("push.t2", 8'h04, 8'h00, 3'b000, S_DOUT | S_BUSY);
    tick();
    step_chk("push.t3", 8'h00, 8'h00, 3'b000, S_WREN | S_DONE | S_BUSY);
    tick();
    ir = mk(4'd10, 3'd7, 3'd0);
    #1;
    step_chk("pop.t0", 8'h20, 8'h00, 3'b000, S_ADDR);
    tick();
    step_chk("pop.t1", 8'h00, 8'h00, 3'b000, S_MRD | S_BUSY);
    tick();
    step_chk("pop.t2", 8'h00, 8'h80, 3'b000, S_MOUT | S_SPI | S_DONE | S_BUSY);
    tick();

    // Illegal opcode, then run low in T0 must not capture ir
    ir = mk(4'hF, 3'd1, 3'd1);
    #1;
    step_chk("illegal", 8'h00, 8'h00, 3'b000, S_DONE | S_ILL);
    ir = mk(4'd2, 3'd1, 3'd1);
    run = 1'b0;
    tick();
    ir = mk(4'd0, 3'd0, 3'd7);
    run = 1'b1;
    #1;
    step_chk("t0_stall_mv", 8'h80, 8'h01, 3'b000, S_DONE);
    tick();

    // ST R3,R4 abandoned by reset in T1, then fresh decode
    ir = mk(4'd5, 3'd3, 3'd4);
    #1;
    step_chk("st.t0", 8'h10, 8'h00, 3'b000, S_ADDR);
    tick();
    step_chk("st.t1", 8'h08, 8'h00, 3'b000, S_DOUT | S_BUSY);
    resetn = 1'b0;
    #1;
    step_chk("st.reset", 8'h00, 8'h00, 3'b000, 16'h0000);
    tick();
    step_chk("st.reset_hold", 8'h00, 8'h00, 3'b000, 16'h0000);
    resetn = 1'b1;
    ir = mk(4'd0, 3'd1, 3'd2);
    #1;
    step_chk("after_reset_mv", 8'h04, 8'h02, 3'b000, S_DONE);

    // NREG=16 build: LD R15,R9
    ir16 = {4'd4, 4'd15, 4'd9};
    #1;
    expect_eq("ld16.t0.r_out", w_r_out, 16'h0200);
    expect_eq("ld16.t0.addr_in", w_addr_in, 1'b1);
    tick();
    expect_eq("ld16.t1.mem_rd", w_mem_rd, 1'b1);
    expect_eq("ld16.t1.busy", w_busy, 1'b1);
    tick();
    expect_eq("ld16.t2.idle", {w_r_in, w_r_out, w_mem_rd, w_mem_out, w_done}, 35'd0);
    expect_eq("ld16.t2.busy", w_busy, 1'b1);
    tick();
    expect_eq("ld16.t3.r_in", w_r_in, 16'h8000);
    expect_eq("ld16.t3.mem_out_done", {w_mem_out, w_done}, 2'b11);
    tick();
    ir16 = '0;
    #1;
    expect_eq("ld16.next_t0", {w_r_in, w_r_out, w_done, w_busy}, {16'h0001, 16'h0001, 1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
